// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: runs one execute-stage memory request over a valid/ready bus, aligns byte
// lanes, extends loads, flags misalignment/bus/timeout faults and hands back write-back data.
module ysyx_23060332_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_raddr,
  input  logic [31:0] mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_wdata,
  input  logic [4:0]  waddr_i,
  input  logic        reg_wen_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wdata,
  output logic [4:0]  waddr_o,
  output logic        reg_wen_o,
  output logic        err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  input  logic        bus_resp_err
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        is_load;
  logic [1:0]  off;
  logic [2:0]  f3;

  logic [31:0] acc_addr;
  logic [1:0]  acc_off;
  logic        half_acc;
  logic        word_acc;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;
  logic        unused_wmask;

  assign in_ready     = (state == StIdle);
  assign unused_wmask = ^mem_wmask[7:4];

  assign acc_addr = mem_ren ? mem_raddr : mem_waddr;
  assign acc_off  = acc_addr[1:0];
  assign st_wdata = mem_wdata << {acc_off, 3'b000};
  assign st_strb  = mem_wmask[3:0] << acc_off;

  // Access size comes from func3 for loads and from the byte mask for stores.
  always_comb begin
    half_acc = 1'b0;
    word_acc = 1'b0;
    if (mem_ren) begin
      word_acc = func3[1];
      half_acc = (func3[1:0] == 2'b01);
    end else begin
      word_acc = |mem_wmask[3:2];
      half_acc = !word_acc && mem_wmask[1];
    end
    misaligned = (half_acc && acc_off[0]) || (word_acc && (acc_off != 2'b00));
  end

  always_comb begin
    ld_shift = bus_resp_rdata >> {off, 3'b000};
    case (f3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      cnt           <= '0;
      is_load       <= 1'b0;
      off           <= 2'b00;
      f3            <= 3'b000;
      out_valid     <= 1'b0;
      wdata         <= '0;
      waddr_o       <= '0;
      reg_wen_o     <= 1'b0;
      err           <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_wstrb     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            waddr_o   <= waddr_i;
            reg_wen_o <= reg_wen_i;
            err       <= 1'b0;
            is_load   <= mem_ren;
            off       <= acc_off;
            f3        <= func3;
            cnt       <= '0;
            if (!mem_ren && !mem_wen) begin
              wdata     <= alu_wdata;
              out_valid <= 1'b1;
              state     <= StDone;
            end else if ((mem_ren && mem_wen) || misaligned) begin
              // Faulting requests never reach the bus.
              wdata     <= '0;
              err       <= 1'b1;
              reg_wen_o <= 1'b0;
              out_valid <= 1'b1;
              state     <= StDone;
            end else begin
              bus_req_valid <= 1'b1;
              bus_we        <= mem_wen;
              bus_addr      <= {acc_addr[31:2], 2'b00};
              bus_wdata     <= mem_wen ? st_wdata : '0;
              bus_wstrb     <= mem_wen ? st_strb : 4'b0000;
              state         <= StReq;
            end
          end
        end
        StReq: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= StResp;
          end
        end
        StResp: begin
          if (bus_resp_valid) begin
            wdata <= is_load ? ld_data : '0;
            if (bus_resp_err) begin
              err       <= 1'b1;
              reg_wen_o <= 1'b0;
            end
            out_valid <= 1'b1;
            state     <= StDone;
          end else if (cnt + 32'd1 >= TIMEOUT) begin
            wdata     <= '0;
            err       <= 1'b1;
            reg_wen_o <= 1'b0;
            out_valid <= 1'b1;
            state     <= StDone;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed bench for ysyx_23060332_lsu: each vector is scheduled against a transaction-level
// model, and a negedge compare process checks every output on every cycle of the transaction.
module tb_ysyx_23060332_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, alu_wdata;
  logic [7:0]  mem_wmask;
  logic [2:0]  func3;
  logic [4:0]  waddr_i, waddr_o;
  logic        reg_wen_i, reg_wen_o, out_valid, out_ready, err;
  logic [31:0] wdata, bus_addr, bus_wdata, bus_resp_rdata;
  logic        bus_req_valid, bus_req_ready, bus_we, bus_resp_valid, bus_resp_err;
  logic [3:0]  bus_wstrb;

  ysyx_23060332_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .func3(func3), .alu_wdata(alu_wdata),
    .waddr_i(waddr_i), .reg_wen_i(reg_wen_i), .out_valid(out_valid), .out_ready(out_ready),
    .wdata(wdata), .waddr_o(waddr_o), .reg_wen_o(reg_wen_o), .err(err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_err(bus_resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mode: 0 = good response, 1 = error response, 2 = no response (timeout)
  typedef struct {
    logic        ren, wen;
    logic [31:0] raddr, maddr, mwdata, alu, rdata;
    logic [7:0]  wmask;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rwen, junk;
    int          rqw, rsw, mode, hold;
  } txn_t;

  txn_t        cur, t;
  bit          active = 0;
  int          t0, done_c, end_c;
  bit          bus_exp;
  logic [31:0] e_wdata, e_addr, e_bwdata;
  logic [3:0]  e_strb;
  logic        e_err, e_rwen;
  logic [31:0] seen_wdata, seen_bwdata;
  logic [3:0]  seen_strb;
  logic        seen_err, seen_rwen;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic txn_t blank();
    txn_t b;
    b.ren = 0; b.wen = 0; b.raddr = 0; b.maddr = 0; b.mwdata = 0; b.alu = 0; b.rdata = 0;
    b.wmask = 0; b.f3 = 0; b.rd = 0; b.rwen = 0; b.junk = 0;
    b.rqw = 0; b.rsw = 0; b.mode = 0; b.hold = 0;
    return b;
  endfunction

  // Expected results straight from the access rules: size, alignment, lanes, extension.
  task automatic model(input txn_t x);
    logic [31:0]        addr, r;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int                 off, sz;
    addr = x.ren ? x.raddr : x.maddr;
    off  = int'(addr[1:0]);
    if (x.ren) begin
      case (x.f3)
        3'b000, 3'b100: sz = 1;
        3'b001, 3'b101: sz = 2;
        default:        sz = 4;
      endcase
    end else begin
      case (x.wmask[3:0])
        4'b0001: sz = 1;
        4'b0011: sz = 2;
        default: sz = 4;
      endcase
    end
    bus_exp  = (x.ren != x.wen) && (off % sz == 0);
    e_err    = (x.ren && x.wen) || ((x.ren || x.wen) && (off % sz != 0)) ||
               (bus_exp && x.mode != 0);
    e_rwen   = e_err ? 1'b0 : x.rwen;
    e_addr   = {addr[31:2], 2'b00};
    e_bwdata = x.wen ? (x.mwdata << (8 * off)) : 32'd0;
    e_strb   = 4'b0000;
    if (x.wen) for (int i = off; i < off + sz && i < 4; i++) e_strb[i] = 1'b1;
    r  = x.rdata >> (8 * off);
    sb = r[7:0];
    sh = r[15:0];
    if (!x.ren && !x.wen) e_wdata = x.alu;
    else if (x.wen) e_wdata = 32'd0;
    else begin
      case (x.f3)
        3'b000:  e_wdata = 32'(sb);
        3'b001:  e_wdata = 32'(sh);
        3'b100:  e_wdata = {24'd0, r[7:0]};
        3'b101:  e_wdata = {16'd0, r[15:0]};
        default: e_wdata = r;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      automatic int  c    = cyc;
      automatic bit  rq   = bus_exp && c >= t0 + 1 && c <= t0 + 1 + cur.rqw;
      automatic bit  ov   = c >= done_c && c <= end_c;
      check("in_ready", in_ready, c == t0);
      check("bus_req_valid", bus_req_valid, rq);
      if (rq) begin
        check("bus_addr", bus_addr, e_addr);
        check("bus_we", bus_we, cur.wen);
        check("bus_wdata", bus_wdata, e_bwdata);
        check("bus_wstrb", bus_wstrb, e_strb);
        seen_bwdata = bus_wdata;
        seen_strb   = bus_wstrb;
      end
      check("out_valid", out_valid, ov);
      if (ov) begin
        check("waddr_o", waddr_o, cur.rd);
        check("reg_wen_o", reg_wen_o, e_rwen);
        check("err", err, e_err);
        if (!e_err) check("wdata", wdata, e_wdata);
        seen_wdata = wdata;
        seen_err   = err;
        seen_rwen  = reg_wen_o;
      end
    end
  end

  // Drives one transaction cycle by cycle; called #1 after a rising edge.
  task automatic run(input txn_t x);
    bit real_resp;
    model(x);
    cur = x;
    t0  = cyc;
    if (!bus_exp) done_c = t0 + 1;
    else if (x.mode == 2) done_c = t0 + 2 + x.rqw + int'(TO);
    else done_c = t0 + 3 + x.rqw + x.rsw;
    end_c = done_c + x.hold;
    seen_wdata = 32'hx; seen_bwdata = 32'hx; seen_strb = 4'hx; seen_err = 1'bx; seen_rwen = 1'bx;
    mem_ren = x.ren; mem_wen = x.wen; mem_raddr = x.raddr; mem_waddr = x.maddr;
    mem_wdata = x.mwdata; mem_wmask = x.wmask; func3 = x.f3; alu_wdata = x.alu;
    waddr_i = x.rd; reg_wen_i = x.rwen;
    active = 1;
    for (int c = t0; c <= end_c; c++) begin
      real_resp      = bus_exp && x.mode != 2 && c == t0 + 2 + x.rqw + x.rsw;
      in_valid       = (c == t0);
      bus_req_ready  = bus_exp && c == t0 + 1 + x.rqw;
      // Stray responses during REQ must be ignored.
      bus_resp_valid = real_resp || (x.junk && c >= t0 + 1 && c <= t0 + 1 + x.rqw);
      bus_resp_err   = real_resp ? (x.mode == 1) : x.junk;
      bus_resp_rdata = real_resp ? x.rdata : 32'hDEAD_BEEF;
      out_ready      = (c == end_c);
      @(posedge clk);
      #1;
    end
    active = 0;
    in_valid = 0; bus_req_ready = 0; bus_resp_valid = 0; bus_resp_err = 0; out_ready = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; mem_ren = 0; mem_wen = 0; mem_raddr = 0; mem_waddr = 0;
    mem_wdata = 0; mem_wmask = 0; func3 = 0; alu_wdata = 0; waddr_i = 0; reg_wen_i = 0;
    out_ready = 0; bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = 0; bus_resp_err = 0;
    #3;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst bus_req_valid", bus_req_valid, 0);
    check("rst err", err, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;

    t = blank(); t.alu = 32'h1234; t.rd = 5; t.rwen = 1;
    run(t);
    check("pass wdata lit", seen_wdata, 32'h1234);

    t = blank(); t.ren = 1; t.raddr = 32'h8000_0003; t.rdata = 32'hAB00_0000; t.rd = 3; t.rwen = 1;
    run(t);
    check("lb lit", seen_wdata, 32'hFFFF_FFAB);
    t.f3 = 3'b100;
    run(t);
    check("lbu lit", seen_wdata, 32'h0000_00AB);

    t = blank(); t.wen = 1; t.maddr = 32'h8000_0002; t.mwdata = 32'h0000_BEEF; t.wmask = 8'h03;
    t.rqw = 3; t.junk = 1; t.rd = 9; t.rwen = 0;
    run(t);
    check("sh bus_wdata lit", seen_bwdata, 32'hBEEF_0000);
    check("sh bus_wstrb lit", seen_strb, 4'b1100);

    t = blank(); t.ren = 1; t.raddr = 32'h8000_0001; t.f3 = 3'b010; t.rd = 4; t.rwen = 1;
    run(t);
    check("mis err lit", seen_err, 1);
    check("mis rwen lit", seen_rwen, 0);

    t = blank(); t.ren = 1; t.raddr = 32'h8000_0004; t.f3 = 3'b010; t.mode = 2; t.rd = 6;
    t.rwen = 1; t.rqw = 1;
    run(t);
    check("timeout err lit", seen_err, 1);

    t = blank(); t.ren = 1; t.raddr = 32'h8000_0002; t.f3 = 3'b001; t.mode = 1; t.rd = 8;
    t.rwen = 1; t.rdata = 32'h1111_2222;
    run(t);
    check("bus err lit", seen_rwen, 0);

    t = blank(); t.ren = 1; t.raddr = 32'h8000_0002; t.f3 = 3'b101; t.rdata = 32'h8001_0000;
    t.rsw = 2; t.hold = 5; t.rd = 10; t.rwen = 1;
    run(t);
    check("lhu lit", seen_wdata, 32'h0000_8001);
    t.f3 = 3'b001; t.hold = 0; t.rsw = 0; t.rwen = 0;
    run(t);
    check("lh lit", seen_wdata, 32'hFFFF_8001);

    t = blank(); t.wen = 1; t.maddr = 32'h8000_0008; t.mwdata = 32'h1234_5678; t.wmask = 8'hFF;
    t.rsw = 1; t.rd = 1; t.rwen = 0;
    run(t);

    t = blank(); t.wen = 1; t.maddr = 32'h8000_0011; t.mwdata = 32'h0000_00A5; t.wmask = 8'h01;
    run(t);
    check("sb bus_wdata lit", seen_bwdata, 32'h0000_A500);

    t = blank(); t.ren = 1; t.wen = 1; t.raddr = 32'h8000_0000; t.rd = 2; t.rwen = 1;
    run(t);
    check("ren+wen err lit", seen_err, 1);

    // Reset in the middle of a load waiting in RESP.
    t0 = cyc;
    mem_ren = 1; mem_wen = 0; mem_raddr = 32'h8000_0010; func3 = 3'b010; waddr_i = 7;
    reg_wen_i = 1; in_valid = 1;
    @(posedge clk); #1 in_valid = 0; bus_req_ready = 1;
    @(posedge clk); #1 bus_req_ready = 0;
    check("resp in_ready", in_ready, 0);
    check("resp waddr_o", waddr_o, 7);
    #2 rst = 1;
    #1;
    check("mid rst in_ready", in_ready, 1);
    check("mid rst out_valid", out_valid, 0);
    check("mid rst wdata", wdata, 0);
    check("mid rst waddr_o", waddr_o, 0);
    check("mid rst reg_wen_o", reg_wen_o, 0);
    check("mid rst err", err, 0);
    check("mid rst bus_req_valid", bus_req_valid, 0);
    check("mid rst bus_we", bus_we, 0);
    check("mid rst bus_addr", bus_addr, 0);
    check("mid rst bus_wdata", bus_wdata, 0);
    check("mid rst bus_wstrb", bus_wstrb, 0);
    @(posedge clk); #1 rst = 0;
    check("post rst in_ready", in_ready, 1);

    t = blank(); t.alu = 32'hCAFE_F00D; t.rd = 31; t.rwen = 1;
    run(t);
    check("recover lit", seen_wdata, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
